pmcd_ce_gen: RTL and testbench

- Parametrised, single-clock successor to the phase-matched clock divider primitive.
- Produces NUM_DIV phase-aligned divided outputs. Each output is a one-cycle clock-enable pulse plus a square-wave level.
- Each channel has its own runtime-programmable divisor.
- Sits beside clock-management logic and drives CE-based slow domains instead of real derived clocks. Keeps the release (REL) gating and adds re-phasing on divisor load.

---
 rtl/pmcd_pkg.sv | 19 +
 rtl/pmcd_div_chan.sv | 47 ++++
 rtl/pmcd_ce_gen.sv | 105 ++++++++++
 tb/tb_pmcd_ce_gen.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pmcd_pkg.sv
// Shared types and helpers for the pmcd_ce_gen clock-enable divider.
// The optional deferred-load build is selected with PMCD_DEFER_LOAD_EN.
package pmcd_pkg;

    typedef enum logic [1:0] {
        ST_RESET,
        ST_WAIT_REL,
        ST_RUN
    } pmcd_state_e;

    localparam int PMCD_NUM_DIV = 4;
    localparam int PMCD_CNT_W   = 8;

    // Length of the high phase of DIVO: odd divisors get the extra cycle.
    function automatic logic [31:0] ceil_half(input logic [31:0] d);
        return (d >> 1) + {31'b0, d[0]};
    endfunction

endpackage

// File: rtl/pmcd_div_chan.sv
// One divided channel: shadow divisor, modulo-d counter and CE/DIVO decode.
// Used by pmcd_ce_gen in both the immediate and PMCD_DEFER_LOAD_EN builds.
module pmcd_div_chan
    import pmcd_pkg::*;
#(
    parameter int CNT_W = PMCD_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_run,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_div,
    output logic             o_ce,
    output logic             o_divo,
    output logic             o_en,
    output logic             o_at_zero,
    output logic             o_at_last
);

    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_last_val;
    logic [31:0]      w_half;

    assign o_en       = (r_div != '0);
    assign w_last_val = r_div - CNT_W'(1);
    assign o_at_zero  = (r_cnt == '0);
    assign o_at_last  = o_en && (r_cnt == w_last_val);
    assign w_half     = ceil_half(32'(r_div));

    assign o_ce   = i_run && o_en && o_at_zero;
    assign o_divo = i_run && o_en && (32'(r_cnt) < w_half);

    // Wrap is an explicit compare against d-1 so d = 2^CNT_W-1 is exact.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div <= i_div;
            r_cnt <= '0;
        end else if (i_load) begin
            r_div <= i_div;
            r_cnt <= '0;
        end else if (i_run) begin
            r_cnt <= (o_at_last || !o_en) ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pmcd_ce_gen.sv
// Phase-matched multi-channel clock-enable generator with REL gating and re-phase on LOAD.
// Define PMCD_DEFER_LOAD_EN to hold LOAD until the common period boundary.
module pmcd_ce_gen
    import pmcd_pkg::*;
#(
    parameter int NUM_DIV = PMCD_NUM_DIV,
    parameter int CNT_W   = PMCD_CNT_W,
    parameter int EN_REL  = 0
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     REL,
    input  logic                     LOAD,
    input  logic [NUM_DIV*CNT_W-1:0] DIV_VEC,
    output logic [NUM_DIV-1:0]       CE,
    output logic [NUM_DIV-1:0]       DIVO,
    output logic                     ALIGN,
    output logic                     RUNNING,
    output logic                     LOAD_DONE
);

    pmcd_state_e r_state;
    pmcd_state_e w_state_nxt;

    logic [NUM_DIV-1:0]       w_en;
    logic [NUM_DIV-1:0]       w_at_zero;
    logic [NUM_DIV-1:0]       w_at_last;
    logic [NUM_DIV*CNT_W-1:0] w_load_vec;
    logic                     w_run;
    logic                     w_run_load;
    logic                     w_chan_load;
    logic                     r_load_done;

    assign w_run = (r_state == ST_RUN);

    always_ff @(posedge CLK) begin
        if (RST) r_state <= ST_RESET;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RESET:    w_state_nxt = (EN_REL != 0) ? ST_WAIT_REL : ST_RUN;
            ST_WAIT_REL: if (REL) w_state_nxt = ST_RUN;
            ST_RUN:      w_state_nxt = ST_RUN;
            default:     w_state_nxt = ST_RESET;
        endcase
    end

`ifdef PMCD_DEFER_LOAD_EN
    logic                     r_pend;
    logic [NUM_DIV*CNT_W-1:0] r_pend_vec;
    logic                     w_boundary;

    // A LOAD landing on the boundary edge itself is applied at once with its own value.
    assign w_boundary = &(w_at_last | ~w_en);
    assign w_run_load = w_run && (LOAD || r_pend) && w_boundary;
    assign w_load_vec = LOAD ? DIV_VEC : r_pend_vec;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pend     <= 1'b0;
            r_pend_vec <= '0;
        end else if (w_run) begin
            if (LOAD) r_pend_vec <= DIV_VEC;
            r_pend <= (LOAD || r_pend) && !w_boundary;
        end
    end
`else
    logic w_unused;

    assign w_run_load = w_run && LOAD;
    assign w_load_vec = DIV_VEC;
    assign w_unused   = ^w_at_last;
`endif

    // LOAD is a single-cycle strobe; outside RUN it only refreshes the shadow divisors.
    assign w_chan_load = w_run ? w_run_load : LOAD;

    for (genvar g = 0; g < NUM_DIV; g++) begin : g_chan
        pmcd_div_chan #(.CNT_W(CNT_W)) u_chan (
            .i_clk    (CLK),
            .i_rst    (RST),
            .i_run    (w_run),
            .i_load   (w_chan_load),
            .i_div    (w_load_vec[g*CNT_W +: CNT_W]),
            .o_ce     (CE[g]),
            .o_divo   (DIVO[g]),
            .o_en     (w_en[g]),
            .o_at_zero(w_at_zero[g]),
            .o_at_last(w_at_last[g])
        );
    end

    always_ff @(posedge CLK) begin
        if (RST) r_load_done <= 1'b0;
        else     r_load_done <= w_run_load;
    end

    assign ALIGN     = w_run && (|w_en) && (&(w_at_zero | ~w_en));
    assign RUNNING   = w_run;
    assign LOAD_DONE = r_load_done;

endmodule

// File: tb/tb_pmcd_ce_gen.sv
// Randomised scoreboard bench for pmcd_ce_gen, two instances (EN_REL=0 and EN_REL=1).
// Reference model tracks time since the last re-phase and derives phases with modulo arithmetic.
module tb_pmcd_ce_gen;

    localparam int N = 4;
    localparam int W = 8;

    logic           CLK = 1'b0;
    logic           RST;
    logic           REL;
    logic           LOAD;
    logic [N*W-1:0] DIV_VEC;

    logic [N-1:0] a_ce, a_divo, b_ce, b_divo;
    logic         a_align, a_run, a_ld, b_align, b_run, b_ld;

    always #5 CLK = ~CLK;

    pmcd_ce_gen #(.NUM_DIV(N), .CNT_W(W), .EN_REL(0)) u_dut (
        .CLK(CLK), .RST(RST), .REL(REL), .LOAD(LOAD), .DIV_VEC(DIV_VEC),
        .CE(a_ce), .DIVO(a_divo), .ALIGN(a_align), .RUNNING(a_run), .LOAD_DONE(a_ld)
    );

    pmcd_ce_gen #(.NUM_DIV(N), .CNT_W(W), .EN_REL(1)) u_dut_rel (
        .CLK(CLK), .RST(RST), .REL(REL), .LOAD(LOAD), .DIV_VEC(DIV_VEC),
        .CE(b_ce), .DIVO(b_divo), .ALIGN(b_align), .RUNNING(b_run), .LOAD_DONE(b_ld)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [21:0] exp_q[$];

    // Model state per instance: 0 = reset, 1 = waiting for release, 2 = running.
    int mst[2];
    int md[2][N];
    int mt[2];
    bit mpend[2];
    int mpv[2][N];
    bit mld[2];

    function automatic logic [N*W-1:0] vec4(input int c3, input int c2, input int c1, input int c0);
        logic [W-1:0] v3, v2, v1, v0;
        v3 = W'(c3); v2 = W'(c2); v1 = W'(c1); v0 = W'(c0);
        return {v3, v2, v1, v0};
    endfunction

    task automatic model_step(input int m);
        mld[m] = 1'b0;
        if (RST) begin
            mst[m] = 0;
            for (int i = 0; i < N; i++) md[m][i] = int'(DIV_VEC[i*W +: W]);
            mt[m] = 0;
            mpend[m] = 1'b0;
        end else if (mst[m] != 2) begin
            if (LOAD) for (int i = 0; i < N; i++) md[m][i] = int'(DIV_VEC[i*W +: W]);
            mt[m] = 0;
            if (mst[m] == 0) mst[m] = (m == 1) ? 1 : 2;
            else if (REL)    mst[m] = 2;
        end else begin
`ifdef PMCD_DEFER_LOAD_EN
            bit bnd = 1'b1;
            if (LOAD) begin
                mpend[m] = 1'b1;
                for (int i = 0; i < N; i++) mpv[m][i] = int'(DIV_VEC[i*W +: W]);
            end
            for (int i = 0; i < N; i++)
                if (md[m][i] != 0 && ((mt[m] + 1) % md[m][i]) != 0) bnd = 1'b0;
            if (mpend[m] && bnd) begin
                for (int i = 0; i < N; i++) md[m][i] = mpv[m][i];
                mt[m] = 0;
                mpend[m] = 1'b0;
                mld[m] = 1'b1;
            end else begin
                mt[m] = mt[m] + 1;
            end
`else
            if (LOAD) begin
                for (int i = 0; i < N; i++) md[m][i] = int'(DIV_VEC[i*W +: W]);
                mt[m] = 0;
                mld[m] = 1'b1;
            end else begin
                mt[m] = mt[m] + 1;
            end
`endif
        end
    endtask

    function automatic logic [10:0] model_out(input int m);
        logic [N-1:0] ce = '0;
        logic [N-1:0] divo = '0;
        logic run, any_en, all_zero;
        int ph;
        run = (mst[m] == 2);
        any_en = 1'b0;
        all_zero = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (md[m][i] != 0) begin
                any_en = 1'b1;
                ph = mt[m] % md[m][i];
                if (ph == 0) ce[i] = run;
                else         all_zero = 1'b0;
                if (ph < (md[m][i] + 1) / 2) divo[i] = run;
            end
        end
        return {run, mld[m], run & any_en & all_zero, divo, ce};
    endfunction

    // Expected response for the cycle that follows each edge.
    initial begin
        forever begin
            @(posedge CLK);
            model_step(0);
            model_step(1);
            exp_q.push_back({model_out(1), model_out(0)});
        end
    end

    // Monitor: compares every presented cycle against the oldest expectation.
    initial begin
        logic [21:0] e, act;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act = {b_run, b_ld, b_align, b_divo, b_ce, a_run, a_ld, a_align, a_divo, a_ce};
                n_vec++;
                if (act !== e) begin
                    n_err++;
                    $display("FAIL outputs t=%0t: got %b_%b, required %b_%b",
                             $time, act[21:11], act[10:0], e[21:11], e[10:0]);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic load_vec(input logic [N*W-1:0] v);
        LOAD = 1'b1;
        DIV_VEC = v;
        @(negedge CLK);
        LOAD = 1'b0;
    endtask

    // Gap between the first two pulses of ALIGN (sel 0) or CE[0] (sel 1) of instance A.
    task automatic measure(input int sel, input int bound, input int want, input string name);
        int first = -1;
        int gap = -1;
        int k = 0;
        logic sig;
        while (k < bound && gap < 0) begin
            @(negedge CLK);
            k++;
            sig = (sel == 0) ? a_align : a_ce[0];
            if (sig) begin
                if (first < 0) first = k;
                else           gap = k - first;
            end
        end
        n_vec++;
        if (gap != want) begin
            n_err++;
            $display("FAIL %s: measured %0d cycles, required %0d", name, gap, want);
        end
    endtask

    function automatic logic [N*W-1:0] rand_vec();
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) begin
            int r = $urandom_range(0, 9);
            v[i*W +: W] = (r == 9) ? W'($urandom_range(0, 255)) : W'(r);
        end
        return v;
    endfunction

    initial begin
        RST = 1'b1;
        REL = 1'b0;
        LOAD = 1'b0;
        DIV_VEC = vec4(1, 2, 4, 8);
        tick(3);
        RST = 1'b0;
        tick(40);

        REL = 1'b1;
        tick(1);
        REL = 1'b0;
        tick(10);
        for (int i = 0; i < 20; i++) begin
            REL = 1'($urandom_range(0, 1));
            tick(1);
        end
        REL = 1'b0;

        DIV_VEC = vec4(0, 3, 5, 7);
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        measure(0, 300, 105, "align_period");

        load_vec(vec4(6, 6, 6, 6));
        tick(3);
        load_vec(vec4(4, 2, 2, 2));
        tick(12);
        REL = 1'b1;
        tick(1);
        REL = 1'b0;

        load_vec(vec4(4, 2, 1, 1));
        tick(5);
        load_vec(vec4(4, 2, 1, 1));
        tick(10);
        load_vec(vec4(3, 3, 3, 3));
        load_vec(vec4(5, 1, 2, 4));
        tick(30);

        DIV_VEC = vec4(0, 0, 0, 255);
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        tick(201);
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        measure(1, 600, 255, "ce0_period_255");

        for (int i = 0; i < 600; i++) begin
            RST  = ($urandom_range(0, 99) == 0);
            REL  = ($urandom_range(0, 7) == 0);
            LOAD = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 3) == 0) DIV_VEC = rand_vec();
            tick(1);
        end
        RST = 1'b0;
        REL = 1'b0;
        LOAD = 1'b0;
        tick(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
